// File: rtl/ball_link_sender_pkg.sv
// Shared definitions for the ball hand-off transmitter: opponent register map,
// frame layout, FSM state encodings and the ball-frame byte formatter.
package ball_link_pkg;

  localparam logic [7:0] REG_Y_HI = 8'd0;
  localparam logic [7:0] REG_Y_LO = 8'd1;
  localparam logic [7:0] REG_VY   = 8'd2;
  localparam logic [7:0] REG_GRAV = 8'd3;
  localparam logic [7:0] REG_SPD  = 8'd4;
  localparam logic [7:0] REG_GO   = 8'd5;
  localparam logic [7:0] REG_LOSE = 8'd6;

  localparam logic [7:0] GO_SET   = 8'h01;
  localparam logic [7:0] GO_CLR   = 8'h00;
  localparam logic [7:0] LOSE_SET = 8'h01;

  // Ball frame is six bytes (regs 0..5, last one sets go); index 6 is the go-clear write.
  localparam int         BALL_FRAME_LEN = 6;
  localparam logic [2:0] IDX_GO         = 3'(BALL_FRAME_LEN - 1);
  localparam logic [2:0] IDX_GO_CLR     = 3'(BALL_FRAME_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_RSP,
    ST_HOLD,
    ST_DONE,
    ST_ABORT
  } link_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_REQ,
    WR_GAP
  } wr_state_t;

  typedef enum logic {
    FR_BALL = 1'b0,
    FR_LOSE = 1'b1
  } frame_t;

  typedef struct packed {
    logic [9:0] y;
    logic [7:0] vy;
    logic [1:0] grav;
    logic       spd;
  } ball_snap_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } i2c_wr_t;

  // Register/data pair for byte idx of the ball frame (idx 6 = go clear).
  function automatic i2c_wr_t ball_byte(input logic [2:0] idx, input ball_snap_t s);
    i2c_wr_t w;
    w.addr = REG_GO;
    w.data = GO_CLR;
    case (idx)
      3'd0:    begin w.addr = REG_Y_HI; w.data = {s.y[9:8], 6'b0};  end
      3'd1:    begin w.addr = REG_Y_LO; w.data = s.y[7:0];          end
      3'd2:    begin w.addr = REG_VY;   w.data = s.vy;              end
      3'd3:    begin w.addr = REG_GRAV; w.data = {6'b0, s.grav};    end
      3'd4:    begin w.addr = REG_SPD;  w.data = {7'b0, s.spd};     end
      IDX_GO:  begin w.addr = REG_GO;   w.data = GO_SET;            end
      default: begin w.addr = REG_GO;   w.data = GO_CLR;            end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ball_link_sender_if.sv
// Byte-write command port between the hand-off transmitter and the I2C master core.
interface ball_link_i2c_if;
  logic       i2c_req;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_wdata;
  logic       i2c_ack;
  logic       i2c_err;

  modport master (
    output i2c_req, i2c_reg_addr, i2c_wdata,
    input  i2c_ack, i2c_err
  );

  modport slave (
    input  i2c_req, i2c_reg_addr, i2c_wdata,
    output i2c_ack, i2c_err
  );
endinterface

// File: rtl/ball_link_sender_byte_writer.sv
// Single register write to the opponent board: holds req with stable addr/data
// until ack/err, re-issues after err or response timeout, gives up after MAX_RETRY
// re-issues. Reports the outcome as a one-cycle wr_ok / wr_fail in the response cycle.
module link_byte_writer
  import ball_link_pkg::*;
#(
  parameter int ACK_TIMEOUT = 250_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic           clk_25MHZ,
  input  logic           reset,
  input  logic           start,
  input  i2c_wr_t        wr,
  output logic           wr_ok,
  output logic           wr_fail,
  ball_link_i2c_if.master i2c
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  wr_state_t     st_q, st_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  i2c_wr_t       wr_q, wr_d;
  logic          req_q, req_d;
  logic          attempt_bad;

  assign i2c.i2c_req      = req_q;
  assign i2c.i2c_reg_addr = wr_q.addr;
  assign i2c.i2c_wdata    = wr_q.data;

  // Request sequencing; err beats ack, ack beats a timeout landing in the same cycle.
  always_comb begin
    st_d        = st_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    wr_d        = wr_q;
    req_d       = req_q;
    wr_ok       = 1'b0;
    wr_fail     = 1'b0;
    attempt_bad = i2c.i2c_err || (!i2c.i2c_ack && (timer_q == '0));
    case (st_q)
      WR_IDLE: begin
        if (start) begin
          wr_d    = wr;
          req_d   = 1'b1;
          timer_d = TW'(ACK_TIMEOUT - 1);
          retry_d = '0;
          st_d    = WR_REQ;
        end
      end
      WR_REQ: begin
        if (attempt_bad) begin
          req_d = 1'b0;
          if (retry_q == RW'(MAX_RETRY)) begin
            wr_fail = 1'b1;
            st_d    = WR_IDLE;
          end else begin
            retry_d = retry_q + 1'b1;
            st_d    = WR_GAP;
          end
        end else if (i2c.i2c_ack) begin
          req_d = 1'b0;
          wr_ok = 1'b1;
          st_d  = WR_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      WR_GAP: begin
        req_d   = 1'b1;
        timer_d = TW'(ACK_TIMEOUT - 1);
        st_d    = WR_REQ;
      end
      default: st_d = WR_IDLE;
    endcase
  end

  // Writer registers; reset drops req immediately.
  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      st_q    <= WR_IDLE;
      timer_q <= '0;
      retry_q <= '0;
      wr_q    <= '0;
      req_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      wr_q    <= wr_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: rtl/ball_link_sender.sv
// Ball hand-off transmitter: snapshots ball state on a trigger rising edge and writes
// it as a register frame to the opponent board, then pulses go; also forwards LOSE.
//
//  state       | meaning
//  IDLE        | waiting for lose request or ball trigger edge
//  LOAD        | frame selected, byte index reset
//  SEND        | hand current byte to the writer
//  WAIT_RSP    | writer busy; choose next byte / HOLD / DONE / ABORT
//  HOLD        | go register held at 1 for GO_HOLD_CYCLES before clearing
//  DONE        | tx_done pulse
//  ABORT       | tx_error pulse (byte failed after all retries)
module ball_link_sender
  import ball_link_pkg::*;
#(
  parameter int GO_HOLD_CYCLES = 25_000,
  parameter int ACK_TIMEOUT    = 250_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic            clk_25MHZ,
  input  logic            reset,
  input  logic            ball_send_trigger,
  input  logic            send_lose,
  input  logic [9:0]      ball_y,
  input  logic [7:0]      ball_vy,
  input  logic [1:0]      gravity_phase,
  input  logic            speed_fast,
  ball_link_i2c_if.master i2c,
  output logic            busy,
  output logic            tx_done,
  output logic            tx_error
);

  localparam int HW = $clog2(GO_HOLD_CYCLES + 1);

  link_state_t   state_q, state_d;
  frame_t        frame_q, frame_d;
  logic [2:0]    idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  ball_snap_t    snap_q, snap_d;
  logic          trig_q, trig_d;
  logic          lose_pending_q, lose_pending_d;
  logic          ball_pending_q, ball_pending_d;
  logic          ball_edge;
  logic          wr_start, wr_ok, wr_fail;
  i2c_wr_t       wr_cmd;

  assign ball_edge = ball_send_trigger & ~trig_q;
  assign busy      = (state_q != ST_IDLE);
  assign tx_done   = (state_q == ST_DONE);
  assign tx_error  = (state_q == ST_ABORT);

  link_byte_writer #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY)
  ) u_writer (
    .clk_25MHZ (clk_25MHZ),
    .reset     (reset),
    .start     (wr_start),
    .wr        (wr_cmd),
    .wr_ok     (wr_ok),
    .wr_fail   (wr_fail),
    .i2c       (i2c)
  );

  // Frame sequencing: lose wins over a simultaneous ball start, which is then deferred.
  always_comb begin
    state_d        = state_q;
    frame_d        = frame_q;
    idx_d          = idx_q;
    hold_d         = hold_q;
    snap_d         = snap_q;
    trig_d         = ball_send_trigger;
    lose_pending_d = lose_pending_q;
    ball_pending_d = ball_pending_q;
    wr_start       = 1'b0;
    if (frame_q == FR_LOSE) begin
      wr_cmd.addr = REG_LOSE;
      wr_cmd.data = LOSE_SET;
    end else begin
      wr_cmd = ball_byte(idx_q, snap_q);
    end
    if (send_lose && (state_q != ST_IDLE)) lose_pending_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (ball_edge) snap_d = '{y: ball_y, vy: ball_vy, grav: gravity_phase, spd: speed_fast};
        if (send_lose || lose_pending_q) begin
          frame_d        = FR_LOSE;
          lose_pending_d = 1'b0;
          if (ball_edge) ball_pending_d = 1'b1;
          state_d        = ST_LOAD;
        end else if (ball_edge || ball_pending_q) begin
          frame_d        = FR_BALL;
          ball_pending_d = 1'b0;
          state_d        = ST_LOAD;
        end
      end
      ST_LOAD: begin
        idx_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        wr_start = 1'b1;
        state_d  = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (wr_fail) begin
          state_d = ST_ABORT;
        end else if (wr_ok) begin
          if ((frame_q == FR_LOSE) || (idx_q == IDX_GO_CLR)) begin
            state_d = ST_DONE;
          end else if (idx_q == IDX_GO) begin
            hold_d  = HW'(GO_HOLD_CYCLES - 1);
            state_d = ST_HOLD;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SEND;
          end
        end
      end
      ST_HOLD: begin
        if (hold_q == '0) begin
          idx_d   = IDX_GO_CLR;
          state_d = ST_SEND;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset abandons any frame and pending requests.
  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      frame_q        <= FR_BALL;
      idx_q          <= '0;
      hold_q         <= '0;
      snap_q         <= '0;
      trig_q         <= 1'b0;
      lose_pending_q <= 1'b0;
      ball_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_q        <= frame_d;
      idx_q          <= idx_d;
      hold_q         <= hold_d;
      snap_q         <= snap_d;
      trig_q         <= trig_d;
      lose_pending_q <= lose_pending_d;
      ball_pending_q <= ball_pending_d;
    end
  end

endmodule

// File: tb/tb_ball_link_sender.sv
// Directed bench for ball_link_sender with a behavioural I2C slave responder.
`timescale 1ns/1ps
module tb_ball_link_sender;

  localparam int GO_HOLD = 40;
  localparam int ACK_TO  = 30;
  localparam int RETRY   = 3;
  localparam int ACK_DLY = 3;

  typedef logic [15:0] wr_q_t[$];

  logic       clk_25MHZ = 1'b0;
  logic       reset = 1'b1;
  logic       ball_send_trigger = 1'b0;
  logic       send_lose = 1'b0;
  logic [9:0] ball_y = '0;
  logic [7:0] ball_vy = '0;
  logic [1:0] gravity_phase = '0;
  logic       speed_fast = 1'b0;
  logic       busy, tx_done, tx_error;

  ball_link_i2c_if bus();

  ball_link_sender #(
    .GO_HOLD_CYCLES (GO_HOLD),
    .ACK_TIMEOUT    (ACK_TO),
    .MAX_RETRY      (RETRY)
  ) dut (
    .clk_25MHZ         (clk_25MHZ),
    .reset             (reset),
    .ball_send_trigger (ball_send_trigger),
    .send_lose         (send_lose),
    .ball_y            (ball_y),
    .ball_vy           (ball_vy),
    .gravity_phase     (gravity_phase),
    .speed_fast        (speed_fast),
    .i2c               (bus),
    .busy              (busy),
    .tx_done           (tx_done),
    .tx_error          (tx_error)
  );

  always #20 clk_25MHZ = ~clk_25MHZ;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit         no_ack = 1'b0;
  int         err_budget = 0;
  logic [7:0] err_addr = '0;
  int         req_age = 0;

  logic [7:0] log_addr[$];
  logic [7:0] log_data[$];
  int         rise_cyc[$];
  int         gap_q[$];
  int         last_fall = -1;
  logic       req_prev = 1'b0;
  logic [7:0] stab_addr = '0, stab_data = '0;
  int         stab_viol = 0;
  int         done_cnt = 0;
  int         error_cnt = 0;

  always @(posedge clk_25MHZ) cyc++;

  // slave responder: ack ACK_DLY cycles after req; optional err injection / silence
  initial begin
    bus.i2c_ack = 1'b0;
    bus.i2c_err = 1'b0;
    forever begin
      @(negedge clk_25MHZ);
      bus.i2c_ack = 1'b0;
      bus.i2c_err = 1'b0;
      if (reset || !bus.i2c_req) begin
        req_age = 0;
      end else begin
        req_age++;
        if (req_age == ACK_DLY) begin
          if (err_budget > 0 && bus.i2c_reg_addr == err_addr) begin
            bus.i2c_err = 1'b1;
            bus.i2c_ack = (err_budget == 2);
            err_budget--;
          end else if (!no_ack) begin
            bus.i2c_ack = 1'b1;
          end
        end
      end
    end
  end

  // bus monitor: logs each request, gaps, stability and status pulses
  always @(negedge clk_25MHZ) begin
    if (bus.i2c_req && !req_prev) begin
      log_addr.push_back(bus.i2c_reg_addr);
      log_data.push_back(bus.i2c_wdata);
      rise_cyc.push_back(cyc);
      gap_q.push_back(last_fall < 0 ? -1 : cyc - last_fall);
      stab_addr = bus.i2c_reg_addr;
      stab_data = bus.i2c_wdata;
    end else if (bus.i2c_req && (bus.i2c_reg_addr !== stab_addr || bus.i2c_wdata !== stab_data)) begin
      stab_viol++;
    end
    if (!bus.i2c_req && req_prev) last_fall = cyc;
    if (tx_done) done_cnt++;
    if (tx_error) error_cnt++;
    req_prev = bus.i2c_req;
  end

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_25MHZ);
      #1;
    end
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    rise_cyc.delete();
    gap_q.delete();
    last_fall = -1;
    done_cnt  = 0;
    error_cnt = 0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      step(1);
      k++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (log_addr.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check(tag, (log_addr.size() >= n), 1'b1);
  endtask

  function automatic logic [15:0] log_at(input int i);
    if (i < log_addr.size()) return {log_addr[i], log_data[i]};
    return 16'hxxxx;
  endfunction

  function automatic int gap_at(input int i);
    if (i < gap_q.size()) return gap_q[i];
    return -2;
  endfunction

  function automatic int rise_at(input int i);
    if (i < rise_cyc.size()) return rise_cyc[i];
    return -100000;
  endfunction

  function automatic wr_q_t ball_seq(input logic [9:0] y, input logic [7:0] vy,
                                     input logic [1:0] g, input logic s);
    wr_q_t q;
    q.push_back({8'd0, y[9:8], 6'b0});
    q.push_back({8'd1, y[7:0]});
    q.push_back({8'd2, vy});
    q.push_back({8'd3, 6'b0, g});
    q.push_back({8'd4, 7'b0, s});
    q.push_back({8'd5, 8'h01});
    q.push_back({8'd5, 8'h00});
    return q;
  endfunction

  task automatic check_seq(input string tag, input wr_q_t exp);
    check({tag, ".count"}, log_addr.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), log_at(i), exp[i]);
  endtask

  initial begin
    wr_q_t exp;

    // reset state
    step(3);
    check("rst.req", bus.i2c_req, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.tx_done", tx_done, 1'b0);
    check("rst.tx_error", tx_error, 1'b0);
    reset = 1'b0;
    step(2);

    // nominal ball frame, inputs changed right after the start edge
    clear_logs();
    ball_y = 10'h2A5; ball_vy = 8'hFD; gravity_phase = 2'd2; speed_fast = 1'b1;
    ball_send_trigger = 1'b1;
    step(1);
    ball_y = '0; ball_vy = '0; gravity_phase = '0; speed_fast = 1'b0;
    step(1);
    check("ball.busy", busy, 1'b1);
    wait_idle(300, "ball.idle");
    check_seq("ball", ball_seq(10'h2A5, 8'hFD, 2'd2, 1'b1));
    check("ball.byte_gap", gap_at(1), 1);
    check("ball.hold_gap", gap_at(6), GO_HOLD + 1);
    check("ball.done", done_cnt, 1);
    check("ball.txerr", error_cnt, 0);
    ball_send_trigger = 1'b0;
    step(2);

    // err twice on reg 2 (first with ack in the same cycle)
    clear_logs();
    err_addr = 8'd2; err_budget = 2;
    ball_y = 10'h155; ball_vy = 8'h7F; gravity_phase = 2'd1; speed_fast = 1'b0;
    ball_send_trigger = 1'b1;
    step(2);
    wait_idle(400, "retry.idle");
    exp = ball_seq(10'h155, 8'h7F, 2'd1, 1'b0);
    exp.insert(2, exp[2]);
    exp.insert(2, exp[2]);
    check_seq("retry", exp);
    check("retry.done", done_cnt, 1);
    check("retry.txerr", error_cnt, 0);
    ball_send_trigger = 1'b0;
    step(2);

    // no response at all: 4 attempts then abort
    clear_logs();
    no_ack = 1'b1;
    ball_y = 10'h3C0;
    ball_send_trigger = 1'b1;
    step(2);
    wait_idle(600, "abort.idle");
    step(50);
    check_seq("abort", '{16'h00C0, 16'h00C0, 16'h00C0, 16'h00C0});
    check("abort.spacing01", rise_at(1) - rise_at(0), ACK_TO + 1);
    check("abort.spacing23", rise_at(3) - rise_at(2), ACK_TO + 1);
    check("abort.txerr", error_cnt, 1);
    check("abort.done", done_cnt, 0);
    no_ack = 1'b0;
    ball_send_trigger = 1'b0;
    step(2);

    // lose requested while byte 3 is in flight
    clear_logs();
    ball_y = 10'h2A5; ball_vy = 8'hFD; gravity_phase = 2'd2; speed_fast = 1'b1;
    ball_send_trigger = 1'b1;
    wait_log(4, 200, "losemid.byte3");
    send_lose = 1'b1;
    step(1);
    send_lose = 1'b0;
    wait_log(8, 400, "losemid.lose");
    wait_idle(100, "losemid.idle");
    exp = ball_seq(10'h2A5, 8'hFD, 2'd2, 1'b1);
    exp.push_back(16'h0601);
    check_seq("losemid", exp);
    check("losemid.done", done_cnt, 2);
    ball_send_trigger = 1'b0;
    step(2);

    // lose and ball start in the same cycle: lose first
    clear_logs();
    ball_y = 10'h0FF; ball_vy = 8'h80; gravity_phase = 2'd3; speed_fast = 1'b0;
    ball_send_trigger = 1'b1;
    send_lose = 1'b1;
    step(1);
    send_lose = 1'b0;
    wait_log(8, 400, "both.all");
    wait_idle(100, "both.idle");
    exp = ball_seq(10'h0FF, 8'h80, 2'd3, 1'b0);
    exp.push_front(16'h0601);
    check_seq("both", exp);
    check("both.done", done_cnt, 2);

    // trigger level kept high: no re-send
    clear_logs();
    step(2000);
    check("level.writes", log_addr.size(), 0);
    check("level.busy", busy, 1'b0);
    ball_send_trigger = 1'b0;
    step(2);

    // reset during HOLD with a lose pending
    clear_logs();
    ball_send_trigger = 1'b1;
    step(1);
    ball_send_trigger = 1'b0;
    wait_log(6, 200, "hold.go");
    step(10);
    check("hold.busy_pre", busy, 1'b1);
    check("hold.req_pre", bus.i2c_req, 1'b0);
    send_lose = 1'b1;
    step(1);
    send_lose = 1'b0;
    #5 reset = 1'b1;
    #1;
    check("hold.req_rst", bus.i2c_req, 1'b0);
    check("hold.busy_rst", busy, 1'b0);
    step(2);
    reset = 1'b0;
    clear_logs();
    step(200);
    check("hold.after_writes", log_addr.size(), 0);
    check("hold.after_done", done_cnt, 0);

    // reset while a request is outstanding
    clear_logs();
    ball_send_trigger = 1'b1;
    step(1);
    ball_send_trigger = 1'b0;
    wait_log(1, 50, "reqrst.first");
    check("reqrst.req_pre", bus.i2c_req, 1'b1);
    #3 reset = 1'b1;
    #1;
    check("reqrst.req_rst", bus.i2c_req, 1'b0);
    check("reqrst.busy_rst", busy, 1'b0);
    step(2);
    reset = 1'b0;
    clear_logs();
    step(100);
    check("reqrst.after_writes", log_addr.size(), 0);

    check("stability", stab_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
